// File: rtl/threefish_block_in_sub_reg.sv
// Threefish-512 decrypt input stage: captures a ciphertext block with its key material
// and subtracts the selected subkey one 64-bit word per clock, then holds the result.
module threefish_block_in_sub_reg #(
  parameter int                 WORD_W     = 64,
  parameter int                 NUM_WORDS  = 8,
  parameter logic [WORD_W-1:0]  KEY_PARITY = 64'h1BD11BDAA9FC1A22
) (
  input  logic                          inClk,
  input  logic                          inRstN,
  input  logic                          inStart,
  input  logic [WORD_W*NUM_WORDS-1:0]   inBlock,
  input  logic [WORD_W*NUM_WORDS-1:0]   inKey,
  input  logic [2*WORD_W-1:0]           inTweak,
  input  logic [7:0]                    inRound4,
  input  logic                          inRd,
  output logic [WORD_W*NUM_WORDS-1:0]   outBlock,
  output logic                          outValid,
  output logic                          outBusy,
  output logic [1:0]                    dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  logic [511:0] blk_q, blk_d;
  logic [511:0] key_q, key_d;
  logic [127:0] tweak_q, tweak_d;
  logic [7:0]   id_q, id_d;

  logic [63:0]  k8, t0, t1, t2;
  logic [8:0]   ksum, kmod, tsum6, tmod6;
  logic [7:0]   tmod5;
  logic [63:0]  key_word, t_sel5, t_sel6, ks_word;
  logic [63:0]  cur_word, new_word;
  logic         accept;

  // Extended key word k8 and tweak word t2 always come from the registered operands.
  always_comb begin
    k8 = KEY_PARITY;
    for (int i = 0; i < 8; i++) begin
      k8 = k8 ^ key_q[i*64 +: 64];
    end
    t0 = tweak_q[63:0];
    t1 = tweak_q[127:64];
    t2 = t0 ^ t1;
  end

  always_comb begin
    ksum  = {1'b0, id_q} + {6'b0, idx_q};
    kmod  = ksum % 9'd9;
    tmod5 = id_q % 8'd3;
    tsum6 = {1'b0, id_q} + 9'd1;
    tmod6 = tsum6 % 9'd3;

    case (kmod)
      9'd0:    key_word = key_q[63:0];
      9'd1:    key_word = key_q[127:64];
      9'd2:    key_word = key_q[191:128];
      9'd3:    key_word = key_q[255:192];
      9'd4:    key_word = key_q[319:256];
      9'd5:    key_word = key_q[383:320];
      9'd6:    key_word = key_q[447:384];
      9'd7:    key_word = key_q[511:448];
      default: key_word = k8;
    endcase

    case (tmod5)
      8'd0:    t_sel5 = t0;
      8'd1:    t_sel5 = t1;
      default: t_sel5 = t2;
    endcase

    case (tmod6)
      9'd0:    t_sel6 = t0;
      9'd1:    t_sel6 = t1;
      default: t_sel6 = t2;
    endcase

    ks_word = key_word;
    if (idx_q == 3'd5) ks_word = key_word + t_sel5;
    if (idx_q == 3'd6) ks_word = key_word + t_sel6;
    if (idx_q == 3'd7) ks_word = key_word + {56'b0, id_q};

    // Each word is independent: no borrow crosses a word boundary.
    cur_word = blk_q[{idx_q, 6'b0} +: 64];
    new_word = cur_word - ks_word;
  end

  // A new operation may start from IDLE, or from HOLD in the same cycle the result is taken.
  assign accept = inStart && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && inRd));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    blk_d   = blk_q;
    key_d   = key_q;
    tweak_d = tweak_q;
    id_d    = id_q;

    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          state_d = ST_CALC;
          idx_d   = 3'd0;
          blk_d   = inBlock;
          key_d   = inKey;
          tweak_d = inTweak;
          id_d    = inRound4;
        end else if ((state_q == ST_HOLD) && inRd) begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        blk_d[{idx_q, 6'b0} +: 64] = new_word;
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = ST_HOLD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      blk_q   <= '0;
      key_q   <= '0;
      tweak_q <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      blk_q   <= blk_d;
      key_q   <= key_d;
      tweak_q <= tweak_d;
      id_q    <= id_d;
    end
  end

  assign outBlock  = blk_q;
  assign outValid  = (state_q == ST_HOLD);
  assign outBusy   = (state_q == ST_CALC);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_threefish_block_in_sub_reg.sv
// Bench for the Threefish-512 decrypt input stage: vector table, encrypt/decrypt
// round trips, and hand sequences for start/read/reset corner cases.
module tb_threefish_block_in_sub_reg;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [511:0] blk;
  logic [511:0] key;
  logic [127:0] tweak;
  logic [7:0]   sid;
  logic         rd;
  logic [511:0] out_block;
  logic         out_valid;
  logic         out_busy;
  logic [1:0]   dbg_state;

  threefish_block_in_sub_reg dut (
    .inClk    (clk),
    .inRstN   (rst_n),
    .inStart  (start),
    .inBlock  (blk),
    .inKey    (key),
    .inTweak  (tweak),
    .inRound4 (sid),
    .inRd     (rd),
    .outBlock (out_block),
    .outValid (out_valid),
    .outBusy  (out_busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [511:0] exp_q[$];

  typedef struct {
    logic [511:0] blk;
    logic [511:0] key;
    logic [127:0] tweak;
    logic [7:0]   sid;
    logic [511:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  // Reference subkey word from the Threefish key schedule.
  function automatic logic [63:0] ks_word(input logic [511:0] k_in, input logic [127:0] t_in,
                                          input logic [7:0] s, input int i);
    logic [63:0] k[9];
    logic [63:0] t[3];
    logic [63:0] r;
    k[8] = 64'h1BD11BDAA9FC1A22;
    for (int j = 0; j < 8; j++) begin
      k[j] = k_in[64*j +: 64];
      k[8] = k[8] ^ k[j];
    end
    t[0] = t_in[63:0];
    t[1] = t_in[127:64];
    t[2] = t[0] ^ t[1];
    r = k[(int'(s) + i) % 9];
    if (i == 5) r = r + t[int'(s) % 3];
    if (i == 6) r = r + t[(int'(s) + 1) % 3];
    if (i == 7) r = r + {56'b0, s};
    return r;
  endfunction

  function automatic logic [511:0] model_sub(input logic [511:0] b, input logic [511:0] k_in,
                                             input logic [127:0] t_in, input logic [7:0] s);
    logic [511:0] r;
    for (int i = 0; i < 8; i++) r[64*i +: 64] = b[64*i +: 64] - ks_word(k_in, t_in, s, i);
    return r;
  endfunction

  function automatic logic [511:0] model_add(input logic [511:0] b, input logic [511:0] k_in,
                                             input logic [127:0] t_in, input logic [7:0] s);
    logic [511:0] r;
    for (int i = 0; i < 8; i++) r[64*i +: 64] = b[64*i +: 64] + ks_word(k_in, t_in, s, i);
    return r;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!out_valid && n < max) begin
      step();
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout got 0 exp 1 after %0d cycles", n);
    end
  endtask

  task automatic collect(input string name);
    logic [511:0] e;
    if (out_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(name, out_block, e);
    end
  endtask

  task automatic release_result(input string name);
    rd = 1'b1;
    step();
    rd = 1'b0;
    check({name, "_idle_valid"}, {511'b0, out_valid}, 512'd0);
    check({name, "_idle_busy"}, {511'b0, out_busy}, 512'd0);
  endtask

  // Runs one complete operation from IDLE, checking latency and result.
  task automatic run_op(input string name, input logic [511:0] b, input logic [511:0] k_in,
                        input logic [127:0] t_in, input logic [7:0] s, input logic [511:0] exp);
    int n;
    blk = b; key = k_in; tweak = t_in; sid = s;
    start = 1'b1;
    step();
    start = 1'b0;
    exp_q.push_back(exp);
    blk = ~b; key = rand512(); tweak = ~t_in; sid = s + 8'd1;
    wait_valid(20, n);
    check({name, "_latency"}, 512'(n), 512'd8);
    collect(name);
    release_result(name);
  endtask

  initial begin
    int n;
    int busy_cycles;
    logic stable;
    logic [511:0] held, b, k_in, pt, ct;
    logic [127:0] t_in;
    logic [7:0] s;

    rst_n = 1'b0; start = 1'b0; rd = 1'b0;
    blk = '0; key = '0; tweak = '0; sid = '0;

    vecs[0] = '{blk: '0, key: '0, tweak: '0, sid: 8'd1,
                exp: {64'hE42EE4255603E5DD, 448'h0}};
    vecs[1] = '{blk: '0, key: '0, tweak: {64'd3, 64'd5}, sid: 8'd0,
                exp: {64'h0, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFB, 320'h0}};
    b = rand512(); k_in = rand512(); t_in = {$urandom, $urandom, $urandom, $urandom};
    vecs[2] = '{blk: b, key: k_in, tweak: t_in, sid: 8'd18, exp: model_sub(b, k_in, t_in, 8'd18)};
    b = rand512(); k_in = rand512();
    vecs[3] = '{blk: b, key: k_in, tweak: t_in, sid: 8'd200, exp: model_sub(b, k_in, t_in, 8'd200)};
    vecs[4] = '{blk: '1, key: '1, tweak: '1, sid: 8'd9, exp: model_sub('1, '1, '1, 8'd9)};

    repeat (3) step();
    check("reset_block", out_block, 512'd0);
    check("reset_valid", {511'b0, out_valid}, 512'd0);
    check("reset_busy", {511'b0, out_busy}, 512'd0);
    rst_n = 1'b1;
    step();

    // inRd while nothing is held must do nothing
    rd = 1'b1;
    step();
    rd = 1'b0;
    check("idle_rd_valid", {511'b0, out_valid}, 512'd0);
    check("idle_rd_busy", {511'b0, out_busy}, 512'd0);

    for (int v = 0; v < 5; v++) begin
      run_op($sformatf("vec%0d", v), vecs[v].blk, vecs[v].key, vecs[v].tweak, vecs[v].sid,
             vecs[v].exp);
    end

    // encrypt-side AddKey followed by this stage must return the plaintext
    for (int it = 0; it < 200; it++) begin
      pt = rand512(); k_in = rand512();
      t_in = {$urandom, $urandom, $urandom, $urandom};
      s = 8'($urandom_range(0, 18));
      ct = model_add(pt, k_in, t_in, s);
      run_op($sformatf("rt%0d", it), ct, k_in, t_in, s, pt);
    end

    // inStart held through CALC: only the first operation runs
    b = rand512(); k_in = rand512(); t_in = {$urandom, $urandom, $urandom, $urandom};
    blk = b; key = k_in; tweak = t_in; sid = 8'd4;
    start = 1'b1;
    step();
    exp_q.push_back(model_sub(b, k_in, t_in, 8'd4));
    n = 1;
    busy_cycles = 0;
    while (!out_valid && n < 20) begin
      if (out_busy) busy_cycles++;
      blk = rand512(); key = rand512(); sid = 8'($urandom_range(0, 18));
      step();
      n++;
    end
    check("hold_start_latency", 512'(n), 512'd9);
    check("hold_start_busy", 512'(busy_cycles), 512'd8);
    start = 1'b0;
    collect("hold_start_result");
    release_result("hold_start");

    // HOLD without inRd keeps the block; then read and restart in one cycle
    b = rand512(); k_in = rand512();
    run_op("pre_hold", b, k_in, t_in, 8'd7, model_sub(b, k_in, t_in, 8'd7));
    b = rand512();
    blk = b; key = k_in; tweak = t_in; sid = 8'd11;
    start = 1'b1;
    step();
    start = 1'b0;
    exp_q.push_back(model_sub(b, k_in, t_in, 8'd11));
    wait_valid(20, n);
    held = out_block;
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      rd = 1'b0;
      start = 1'($urandom_range(0, 1));
      blk = rand512(); sid = 8'($urandom_range(0, 18));
      step();
      if (out_block !== held || !out_valid) stable = 1'b0;
    end
    check("hold_stable", {511'b0, stable}, 512'd1);
    collect("hold_result");
    b = rand512(); k_in = rand512();
    blk = b; key = k_in; sid = 8'd15;
    start = 1'b1; rd = 1'b1;
    step();
    start = 1'b0; rd = 1'b0;
    exp_q.push_back(model_sub(b, k_in, t_in, 8'd15));
    check("restart_valid", {511'b0, out_valid}, 512'd0);
    check("restart_busy", {511'b0, out_busy}, 512'd1);
    wait_valid(20, n);
    check("restart_latency", 512'(n), 512'd8);
    collect("restart_result");
    release_result("restart");

    // asynchronous reset in the middle of CALC
    blk = rand512(); key = rand512(); sid = 8'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_block", out_block, 512'd0);
    check("areset_valid", {511'b0, out_valid}, 512'd0);
    check("areset_busy", {511'b0, out_busy}, 512'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (10) step();
    check("post_reset_valid", {511'b0, out_valid}, 512'd0);
    check("post_reset_busy", {511'b0, out_busy}, 512'd0);
    b = rand512(); k_in = rand512();
    run_op("post_reset", b, k_in, t_in, 8'd3, model_sub(b, k_in, t_in, 8'd3));

    check("queue_empty", 512'(exp_q.size()), 512'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
